// File: rtl/ahb_pkg.sv
// Shared AHB-Lite endpoint definitions: transfer state encoding, htrans codes,
// register map constants and the slave FSM enum consumed by the decoder.
package ahb_pkg;

  localparam int AHB_ADDR_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_ERROR = 2'b11
  } xfer_state_e;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [AHB_ADDR_W-1:0] ADDR_STATUS = 7'h40;
  localparam logic [AHB_ADDR_W-1:0] ADDR_ERROR  = 7'h42;
  localparam logic [AHB_ADDR_W-1:0] ADDR_BO     = 7'h44;
  localparam logic [AHB_ADDR_W-1:0] ADDR_EHTS   = 7'h48;

  typedef enum logic [2:0] {
    FSM_IDLE  = 3'd0,
    FSM_WRITE = 3'd1,
    FSM_READ  = 3'd2,
    FSM_ERR1  = 3'd3,
    FSM_ERR2  = 3'd4
  } fsm_e;

  function automatic xfer_state_e fsm_to_state(input fsm_e f);
    xfer_state_e s;
    case (f)
      FSM_WRITE:          s = ST_WRITE;
      FSM_READ:           s = ST_READ;
      FSM_ERR1, FSM_ERR2: s = ST_ERROR;
      default:            s = ST_IDLE;
    endcase
    return s;
  endfunction

  // hsize=3 is never legal, so it maps to zero bytes.
  function automatic logic [2:0] size_bytes(input logic [1:0] hsize);
    logic [2:0] n;
    case (hsize)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      2'd2:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_access_checker.sv
// Combinational legality check of an AHB address phase against the endpoint
// register map; also classifies the target as data buffer or EHTS register.
module ahb_access_checker
  import ahb_pkg::*;
#(
  parameter int                ADDR_W  = 7,
  parameter logic [ADDR_W-1:0] BUF_TOP = 7'h3F
) (
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        hsize,
  input  logic              hwrite,
  input  logic              buffer_busy,
  output logic              legal,
  output logic              is_buffer,
  output logic              is_ehts
);

  logic in_status;
  logic is_bo;
  logic mapped;
  logic misaligned;
  logic ro_write;
  logic reg_size_bad;
  logic buf_conflict;
  logic size_bad;

  always_comb begin
    is_buffer    = (haddr <= BUF_TOP);
    is_ehts      = (haddr == ADDR_W'(ADDR_EHTS));
    // STATUS and ERROR together occupy 0x40..0x43.
    in_status    = (haddr >= ADDR_W'(ADDR_STATUS)) && (haddr <= ADDR_W'(ADDR_STATUS + 7'd3));
    is_bo        = (haddr == ADDR_W'(ADDR_BO));
    mapped       = is_buffer || in_status || is_bo || is_ehts;

    size_bad     = (hsize == 2'd3);
    misaligned   = ((hsize == 2'd1) && haddr[0]) ||
                   ((hsize == 2'd2) && (haddr[1:0] != 2'b00));
    ro_write     = hwrite && (in_status || is_bo);
    reg_size_bad = (in_status && (hsize == 2'd2)) ||
                   ((is_bo || is_ehts) && (hsize != 2'd0));
    buf_conflict = is_buffer && buffer_busy;

    legal = mapped && !size_bad && !misaligned && !ro_write &&
            !reg_size_bad && !buf_conflict;
  end

endmodule

// File: rtl/ahb_slave_ctrl.sv
// AHB-Lite slave control stage: samples address phases, drives the decoder state,
// hready/hresp (two-cycle ERROR) and registered one-cycle data-phase strobes.
module ahb_slave_ctrl
  import ahb_pkg::*;
#(
  parameter int                ADDR_W  = 7,
  parameter logic [ADDR_W-1:0] BUF_TOP = 7'h3F
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        hsize,
  input  logic              bufferBusy,
  output logic [1:0]        state,
  output logic              hready,
  output logic              hresp,
  output logic              txWrite,
  output logic              rxRead,
  output logic              ehtsWrite,
  output logic [2:0]        bufBytes
);

  logic legal;
  logic is_buffer;
  logic is_ehts;
  logic accept;

  fsm_e        fsm_q,        fsm_d;
  xfer_state_e state_q,      state_d;
  logic        hready_q,     hready_d;
  logic        hresp_q,      hresp_d;
  logic        tx_write_q,   tx_write_d;
  logic        rx_read_q,    rx_read_d;
  logic        ehts_write_q, ehts_write_d;
  logic [2:0]  buf_bytes_q,  buf_bytes_d;

  ahb_access_checker #(
    .ADDR_W  (ADDR_W),
    .BUF_TOP (BUF_TOP)
  ) u_checker (
    .haddr       (haddr),
    .hsize       (hsize),
    .hwrite      (hwrite),
    .buffer_busy (bufferBusy),
    .legal       (legal),
    .is_buffer   (is_buffer),
    .is_ehts     (is_ehts)
  );

  // hready_q is low only in ERR1, which is what blocks sampling there.
  assign accept = hsel && hready_q &&
                  ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  always_comb begin
    fsm_d = FSM_IDLE;
    if (fsm_q == FSM_ERR1) begin
      fsm_d = FSM_ERR2;
    end else if (accept) begin
      if (!legal)      fsm_d = FSM_ERR1;
      else if (hwrite) fsm_d = FSM_WRITE;
      else             fsm_d = FSM_READ;
    end

    state_d      = fsm_to_state(fsm_d);
    hready_d     = (fsm_d != FSM_ERR1);
    hresp_d      = (fsm_d == FSM_ERR1) || (fsm_d == FSM_ERR2);
    tx_write_d   = (fsm_d == FSM_WRITE) && is_buffer;
    rx_read_d    = (fsm_d == FSM_READ) && is_buffer;
    ehts_write_d = (fsm_d == FSM_WRITE) && is_ehts;
    buf_bytes_d  = (tx_write_d || rx_read_d) ? size_bytes(hsize) : 3'd0;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      fsm_q        <= FSM_IDLE;
      state_q      <= ST_IDLE;
      hready_q     <= 1'b1;
      hresp_q      <= 1'b0;
      tx_write_q   <= 1'b0;
      rx_read_q    <= 1'b0;
      ehts_write_q <= 1'b0;
      buf_bytes_q  <= 3'd0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      hready_q     <= hready_d;
      hresp_q      <= hresp_d;
      tx_write_q   <= tx_write_d;
      rx_read_q    <= rx_read_d;
      ehts_write_q <= ehts_write_d;
      buf_bytes_q  <= buf_bytes_d;
    end
  end

  assign state     = state_q;
  assign hready    = hready_q;
  assign hresp     = hresp_q;
  assign txWrite   = tx_write_q;
  assign rxRead    = rx_read_q;
  assign ehtsWrite = ehts_write_q;
  assign bufBytes  = buf_bytes_q;

endmodule

// File: tb/tb_ahb_slave_ctrl.sv
// Bench for ahb_slave_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the register-map rules.
module tb_ahb_slave_ctrl;

  logic       clk = 1'b0;
  logic       nRst;
  logic       hsel;
  logic [1:0] htrans;
  logic       hwrite;
  logic [6:0] haddr;
  logic [1:0] hsize;
  logic       bufferBusy;
  logic [1:0] state;
  logic       hready;
  logic       hresp;
  logic       txWrite;
  logic       rxRead;
  logic       ehtsWrite;
  logic [2:0] bufBytes;

  int checks = 0;
  int errors = 0;

  ahb_slave_ctrl dut (
    .clk        (clk),
    .nRst       (nRst),
    .hsel       (hsel),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .haddr      (haddr),
    .hsize      (hsize),
    .bufferBusy (bufferBusy),
    .state      (state),
    .hready     (hready),
    .hresp      (hresp),
    .txWrite    (txWrite),
    .rxRead     (rxRead),
    .ehtsWrite  (ehtsWrite),
    .bufBytes   (bufBytes)
  );

  always #5 clk = ~clk;

  // Output vector layout: {state, hready, hresp, txWrite, rxRead, ehtsWrite, bufBytes}
  function automatic logic [9:0] obs();
    return {state, hready, hresp, txWrite, rxRead, ehtsWrite, bufBytes};
  endfunction

  function automatic logic [9:0] ev(input int st, input int hr, input int hp,
                                    input int tx, input int rx, input int eh, input int by);
    return {2'(st), 1'(hr), 1'(hp), 1'(tx), 1'(rx), 1'(eh), 3'(by)};
  endfunction

  task automatic drive(input logic s, input logic [1:0] t, input logic w,
                       input logic [6:0] a, input logic [1:0] z, input logic b);
    hsel = s; htrans = t; hwrite = w; haddr = a; hsize = z; bufferBusy = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register-map legality derived directly from the access rules.
  function automatic bit legal_ref(input int a, input int z, input bit w, input bit busy);
    int nb;
    if (z == 3) return 0;
    nb = 1 << z;
    if ((a % nb) != 0) return 0;
    if (a <= 63)             return !busy;
    if (a >= 64 && a <= 67)  return !w && (z != 2);
    if (a == 68)             return !w && (z == 0);
    if (a == 72)             return (z == 0);
    return 0;
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    nRst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    e = ev(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs(), e); end
    tick();
    nRst = 1'b1;
    drive(1, 2, 1, 7'h04, 2, 0);
    tick();
    e = ev(1, 1, 0, 1, 0, 0, 4);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_pre_write got=%b exp=%b", obs(), e); end
    nRst = 1'b0;
    #1;
    e = ev(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_mid_write got=%b exp=%b", obs(), e); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    nRst = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    drive(1, 2, 1, 7'h04, 2, 0);
    tick();
    e = ev(1, 1, 0, 1, 0, 0, 4);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL b2b_write got=%b exp=%b", obs(), e); end
    drive(1, 3, 0, 7'h08, 2, 0);
    tick();
    e = ev(2, 1, 0, 0, 1, 0, 4);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL b2b_read got=%b exp=%b", obs(), e); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    e = ev(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL b2b_idle got=%b exp=%b", obs(), e); end
  endtask

  task automatic test_ro_error();
    logic [9:0] e;
    drive(1, 2, 1, 7'h40, 0, 0);
    tick();
    e = ev(3, 0, 1, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL ro_err1 got=%b exp=%b", obs(), e); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    e = ev(3, 1, 1, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL ro_err2 got=%b exp=%b", obs(), e); end
    tick();
    e = ev(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL ro_idle got=%b exp=%b", obs(), e); end
  endtask

  task automatic test_misaligned_err2();
    logic [9:0] e;
    drive(1, 2, 0, 7'h41, 1, 0);
    tick();
    e = ev(3, 0, 1, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL mis_err1 got=%b exp=%b", obs(), e); end
    // A legal write shown during ERR1 must be ignored.
    drive(1, 2, 1, 7'h04, 2, 0);
    tick();
    e = ev(3, 1, 1, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL mis_err2 got=%b exp=%b", obs(), e); end
    drive(1, 2, 0, 7'h48, 0, 0);
    tick();
    e = ev(2, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL err2_read_ehts got=%b exp=%b", obs(), e); end
  endtask

  task automatic test_buffer_busy();
    logic [9:0] e;
    drive(1, 2, 1, 7'h10, 0, 1);
    tick();
    e = ev(3, 0, 1, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL busy_err1 got=%b exp=%b", obs(), e); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    e = ev(3, 1, 1, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL busy_err2 got=%b exp=%b", obs(), e); end
    drive(1, 2, 1, 7'h10, 0, 0);
    tick();
    e = ev(1, 1, 0, 1, 0, 0, 1);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL busy_retry got=%b exp=%b", obs(), e); end
  endtask

  task automatic test_ehts_busy_hsize3();
    logic [9:0] e;
    drive(1, 2, 1, 7'h48, 0, 0);
    tick();
    e = ev(1, 1, 0, 0, 0, 1, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL ehts_write got=%b exp=%b", obs(), e); end
    drive(1, 1, 1, 7'h04, 2, 0);
    tick();
    e = ev(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL htrans_busy got=%b exp=%b", obs(), e); end
    drive(1, 2, 0, 7'h00, 3, 0);
    tick();
    e = ev(3, 0, 1, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL hsize3_err1 got=%b exp=%b", obs(), e); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    e = ev(0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL hsize3_idle got=%b exp=%b", obs(), e); end
  endtask

  task automatic test_random();
    logic [9:0] e;
    bit   in_err1 = 0;
    bit   s, w, b, is_buf;
    int   t, a, z;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        nRst = 1'b0;
        #1;
        e = ev(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (obs() !== e) begin errors++; $display("FAIL rand_reset i=%0d got=%b exp=%b", i, obs(), e); end
        in_err1 = 0;
        nRst = 1'b1;
      end
      s = ($urandom_range(0, 9) != 0);
      t = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 127);
        1:       a = $urandom_range(0, 63);
        2:       a = $urandom_range(64, 72);
        default: a = ($urandom_range(0, 1) != 0) ? 72 : 68;
      endcase
      z = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      b = ($urandom_range(0, 3) == 0);
      drive(s, 2'(t), w, 7'(a), 2'(z), b);

      if (in_err1) begin
        e = ev(3, 1, 1, 0, 0, 0, 0);
        in_err1 = 0;
      end else if (s && t >= 2) begin
        if (legal_ref(a, z, w, b)) begin
          is_buf = (a <= 63);
          e = ev(w ? 1 : 2, 1, 0, int'(w && is_buf), int'(!w && is_buf),
                 int'(w && a == 72), is_buf ? (1 << z) : 0);
        end else begin
          e = ev(3, 0, 1, 0, 0, 0, 0);
          in_err1 = 1;
        end
      end else begin
        e = ev(0, 1, 0, 0, 0, 0, 0);
      end

      tick();
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL rand i=%0d sel=%0d tr=%0d wr=%0d addr=%h sz=%0d busy=%0d got=%b exp=%b",
                 i, s, t, w, a, z, b, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ro_error();
    test_misaligned_err2();
    test_buffer_busy();
    test_ehts_busy_hsize3();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
